// File: rtl/bf_mem_bridge.sv
// Memory and byte-I/O bridge for the Brainfuck core bus; streams the program in before releasing the core.
// Optional byte I/O at address 0xFF is built when BF_MEM_IO_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_LOAD | core held in reset, host program bytes accepted
// ST_RUN  | core released, bus decoded against memory / I/O
module bf_mem_bridge #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_write,
  input  logic       bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       cpu_rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic [7:0] in_data,
  output logic       in_ack
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t        state;
  logic [AW-1:0] load_ptr;
  logic [7:0]    addr_q;
  logic [7:0]    mem [DEPTH];

  logic          in_run;
  logic          addr_ph;
  logic          data_wr;
  logic          addr_in_range;
  logic          load_hs;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [7:0]    rdata_nxt;

  assign in_run        = (state == ST_RUN);
  assign addr_ph       = in_run & bus_write & bus_addr;
  assign data_wr       = in_run & bus_write & ~bus_addr;
  assign addr_in_range = (addr_q[7:AW] == '0);
  assign load_hs       = (state == ST_LOAD) & load_valid & load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      load_ptr   <= '0;
      addr_q     <= '0;
      cpu_rst_n  <= 1'b0;
      load_ready <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          load_ready <= 1'b1;
          if (load_hs) begin
            load_ptr <= load_ptr + AW'(1);
            // memory full ends the load without wrapping onto index 0
            if (load_last || (load_ptr == LAST_IDX)) begin
              state      <= ST_RUN;
              load_ready <= 1'b0;
              cpu_rst_n  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cpu_rst_n  <= 1'b1;
          load_ready <= 1'b0;
          if (addr_ph) begin
            addr_q <= bus_wdata;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_ptr;
    mem_wdata = load_data;
    if (load_hs) begin
      mem_we = 1'b1;
    end else if (data_wr && addr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q[AW-1:0];
      mem_wdata = bus_wdata;
    end
  end

  // no reset: program and tape survive a core restart
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef BF_MEM_IO_EN
  logic [7:0] in_hold;
  logic [7:0] out_data_q;
  logic       out_valid_q;
  logic       in_ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_hold     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ack_q    <= 1'b0;
    end else begin
      out_valid_q <= data_wr && (addr_q == 8'hFF);
      in_ack_q    <= addr_ph && (bus_wdata == 8'hFF);
      if (data_wr && (addr_q == 8'hFF)) begin
        out_data_q <= bus_wdata;
      end
      if (addr_ph && (bus_wdata == 8'hFF)) begin
        in_hold <= in_data;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ack    = in_ack_q;
`else
  logic unused_in_data;
  assign unused_in_data = ^in_data;
  assign out_data  = '0;
  assign out_valid = 1'b0;
  assign in_ack    = 1'b0;
`endif

  // a write to the current address is forwarded so it reads back one cycle later
  always_comb begin
    rdata_nxt = '0;
    if (addr_in_range) begin
      rdata_nxt = data_wr ? bus_wdata : mem[addr_q[AW-1:0]];
    end
`ifdef BF_MEM_IO_EN
    else if (addr_q == 8'hFF) begin
      rdata_nxt = in_hold;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata <= '0;
    end else begin
      bus_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_bf_mem_bridge.sv
// Directed bench for bf_mem_bridge: load handshake, bus decode table, 0xFF I/O and reset-mid-run.
module tb_bf_mem_bridge;

`ifdef BF_MEM_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_write, bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       cpu_rst_n;
  logic       load_valid, load_last, load_ready;
  logic [7:0] load_data;
  logic [7:0] out_data, in_data;
  logic       out_valid, in_ack;

  bf_mem_bridge #(.DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .cpu_rst_n(cpu_rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .out_data(out_data), .out_valid(out_valid), .in_data(in_data), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ld_data [64];

  typedef struct {
    logic [7:0] a;
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] fwd;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic a, input logic [7:0] d);
    @(negedge clk);
    bus_write = w;
    bus_addr  = a;
    bus_wdata = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] v);
    step(1'b1, 1'b1, a);
    idle();
    idle();
    v = bus_rdata;
  endtask

  // offers n bytes from ld_data; last_idx<0 means load_last is never set
  task automatic do_load(input int n, input int last_idx, output int acc,
                         output int last_c, output int run_c, output logic [7:0] rd_at_run);
    acc = 0; last_c = -10; run_c = -1; rd_at_run = 8'h00;
    for (int c = 0; c < n + 10; c++) begin
      @(negedge clk);
      if (cpu_rst_n && run_c < 0) begin
        run_c     = c;
        rd_at_run = bus_rdata;
        bus_write = 1'b0; bus_addr = 1'b0; bus_wdata = 8'h00;
      end
      if (acc < n && !cpu_rst_n) begin
        load_valid = 1'b1;
        load_data  = ld_data[acc];
        load_last  = (acc == last_idx);
        if (load_ready) begin
          acc++;
          last_c = c;
        end
      end else begin
        load_valid = 1'b0;
        load_last  = 1'b0;
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    int acc, last_c, run_c;
    logic [7:0] rd_run, v;

    rst = 1'b1;
    bus_write = 0; bus_addr = 0; bus_wdata = 0;
    load_valid = 0; load_data = 0; load_last = 0; in_data = 0;

    vecs[0] = '{8'h05, 8'hA7, 8'h05, 8'hA7, 8'hA7};
    vecs[1] = '{8'h40, 8'h99, 8'h40, 8'h00, 8'h00};
    vecs[2] = '{8'h1F, 8'h5A, 8'h1F, 8'h5A, 8'h5A};
    vecs[3] = '{8'h20, 8'h77, 8'h20, 8'h00, 8'h00};
    vecs[4] = '{8'h03, 8'hC3, 8'h05, 8'hC3, 8'hA7};
    vecs[5] = '{8'h00, 8'h11, 8'h00, 8'h11, 8'h11};
    vecs[6] = '{8'hFF, 8'h99, 8'hFF, 8'h00, 8'h00};

    #3;
    chk("rst cpu_rst_n", cpu_rst_n, 0);
    chk("rst load_ready", load_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ack", in_ack, 0);
    chk("rst out_data", out_data, 0);
    chk("rst bus_rdata", bus_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 3-byte program; a bus address phase held during LOAD must be ignored
    ld_data[0] = 8'h2B; ld_data[1] = 8'h2E; ld_data[2] = 8'h00;
    bus_write = 1'b1; bus_addr = 1'b1; bus_wdata = 8'h01;
    do_load(3, 2, acc, last_c, run_c, rd_run);
    chk("load3 accepted", acc, 3);
    chk("load3 run timing", run_c, last_c + 1);
    chk("load3 load_ready after", load_ready, 0);
    chk("load3 cpu_rst_n after", cpu_rst_n, 1);
    chk("load3 bus ignored", rd_run, 8'h2B);
    read_mem(8'h00, v); chk("load3 mem0", v, 8'h2B);
    read_mem(8'h01, v); chk("load3 mem1", v, 8'h2E);
    read_mem(8'h02, v); chk("load3 mem2", v, 8'h00);

    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, vecs[i].a);
      step(1'b1, 1'b0, vecs[i].x);
      step(1'b1, 1'b1, vecs[i].b);
      chk($sformatf("vec%0d fwd", i), bus_rdata, vecs[i].fwd);
      chk($sformatf("vec%0d out_valid", i), out_valid, (IO_EN && vecs[i].a == 8'hFF) ? 1 : 0);
      idle();
      idle();
      chk($sformatf("vec%0d rdata", i), bus_rdata, vecs[i].rd);
    end

    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b0, 8'h41);
    idle();
    chk("io out_valid pulse", out_valid, IO_EN ? 1 : 0);
    chk("io out_data", out_data, IO_EN ? 8'h41 : 8'h00);
    idle();
    chk("io out_valid end", out_valid, 0);

    step(1'b1, 1'b1, 8'hFF); in_data = 8'h33;
    idle();
    chk("io in_ack pulse", in_ack, IO_EN ? 1 : 0);
    idle();
    chk("io in_ack end", in_ack, 0);
    chk("io in rdata", bus_rdata, IO_EN ? 8'h33 : 8'h00);

    step(1'b1, 1'b1, 8'hFF); in_data = 8'h34;
    step(1'b1, 1'b1, 8'hFF); in_data = 8'h35;
    chk("io b2b ack1", in_ack, IO_EN ? 1 : 0);
    idle();
    chk("io b2b ack2", in_ack, IO_EN ? 1 : 0);
    idle();
    chk("io b2b ack end", in_ack, 0);
    chk("io b2b rdata", bus_rdata, IO_EN ? 8'h35 : 8'h00);
    in_data = 8'h00;

    // asynchronous reset mid-RUN, then a short reload
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst cpu_rst_n", cpu_rst_n, 0);
    chk("async rst load_ready", load_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reload load_ready", load_ready, 1);
    ld_data[0] = 8'h01; ld_data[1] = 8'h02;
    do_load(2, 1, acc, last_c, run_c, rd_run);
    chk("reload accepted", acc, 2);
    chk("reload run timing", run_c, last_c + 1);
    read_mem(8'h00, v); chk("reload mem0", v, 8'h01);
    read_mem(8'h05, v); chk("reload mem5 kept", v, 8'hA7);
    read_mem(8'h1F, v); chk("reload mem31 kept", v, 8'h5A);

    // 40 bytes offered without load_last: memory full ends the load at index 31
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) ld_data[i] = 8'(8'h80 + i);
    do_load(40, -1, acc, last_c, run_c, rd_run);
    chk("full accepted", acc, 32);
    chk("full run timing", run_c, last_c + 1);
    chk("full cpu_rst_n", cpu_rst_n, 1);
    read_mem(8'h1F, v); chk("full mem31", v, 8'h9F);
    read_mem(8'h00, v); chk("full mem0", v, 8'h80);
    read_mem(8'h20, v); chk("full oob read", v, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
